// File: rtl/lat_histogram.sv
// Latency histogram: 32 saturating bins fed by a 2-stage update pipeline,
// a CSR read port, and a one-bin-per-cycle clear sweep.
module lat_histogram #(
  parameter int BIN_SHIFT = 3,
  parameter int NUM_BINS  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lat_valid,
  input  logic [31:0] lat_cycles,
  input  logic        clear_stats,
  input  logic        hist_rd,
  input  logic [7:0]  hist_addr,
  output logic [31:0] hist_data,
  output logic        hist_valid,
  output logic [31:0] sample_total,
  output logic        clear_busy
);

  typedef enum logic {IDLE, SWEEP} state_e;

  state_e                     state_q, state_d;
  logic [4:0]                 idx_q, idx_d;
  logic                       s1_vld_q, s1_vld_d;
  logic [4:0]                 s1_bin_q, s1_bin_d;
  logic [NUM_BINS-1:0][31:0]  bin_q, bin_d;
  logic [31:0]                total_q, total_d;
  logic [31:0]                hist_data_q, hist_data_d;
  logic                       hist_valid_q, hist_valid_d;
  logic [31:0]                shifted;
  logic                       sweep;
  logic                       unused_addr_lsb;

  assign unused_addr_lsb = ^hist_addr[1:0];
  assign sweep           = (state_q == SWEEP);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (clear_stats) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        // A new clear request restarts the full 32-bin sweep.
        if (clear_stats)         idx_d = '0;
        else if (idx_q == 5'd31) state_d = IDLE;
        else                     idx_d = idx_q + 5'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shifted  = lat_cycles >> BIN_SHIFT;
    s1_vld_d = lat_valid && !sweep;
    s1_bin_d = (|shifted[31:5]) ? 5'd31 : shifted[4:0];

    bin_d   = bin_q;
    total_d = total_q;
    if (sweep) begin
      bin_d[idx_q] = '0;
      total_d      = '0;
    end else if (s1_vld_q) begin
      // Register-array read-modify-write: back-to-back hits see the latest count.
      if (bin_q[s1_bin_q] != '1) bin_d[s1_bin_q] = bin_q[s1_bin_q] + 32'd1;
      if (total_q != '1)         total_d = total_q + 32'd1;
    end

    hist_valid_d = hist_rd;
    hist_data_d  = hist_data_q;
    if (hist_rd)
      hist_data_d = (hist_addr[7] || sweep) ? 32'd0 : bin_q[hist_addr[6:2]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      s1_vld_q     <= 1'b0;
      s1_bin_q     <= '0;
      bin_q        <= '0;
      total_q      <= '0;
      hist_data_q  <= '0;
      hist_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      s1_vld_q     <= s1_vld_d;
      s1_bin_q     <= s1_bin_d;
      bin_q        <= bin_d;
      total_q      <= total_d;
      hist_data_q  <= hist_data_d;
      hist_valid_q <= hist_valid_d;
    end
  end

  assign hist_data    = hist_data_q;
  assign hist_valid   = hist_valid_q;
  assign sample_total = total_q;
  assign clear_busy   = sweep;

endmodule

// File: tb/tb_lat_histogram.sv
// Self-checking bench for lat_histogram: directed tables and sequences plus
// randomized traffic against a cycle-level reference model.
module tb_lat_histogram;

  logic        clk = 1'b0;
  logic        rst;
  logic        lat_valid;
  logic [31:0] lat_cycles;
  logic        clear_stats;
  logic        hist_rd;
  logic [7:0]  hist_addr;
  logic [31:0] hist_data;
  logic        hist_valid;
  logic [31:0] sample_total;
  logic        clear_busy;

  int checks = 0;
  int errors = 0;

  lat_histogram #(.BIN_SHIFT(3), .NUM_BINS(32)) dut (
    .clk(clk), .rst(rst), .lat_valid(lat_valid), .lat_cycles(lat_cycles),
    .clear_stats(clear_stats), .hist_rd(hist_rd), .hist_addr(hist_addr),
    .hist_data(hist_data), .hist_valid(hist_valid),
    .sample_total(sample_total), .clear_busy(clear_busy)
  );

  always #5 clk = ~clk;

  // Reference model: counts per bin, running total, one in-flight sample,
  // and the number of clear cycles still to run.
  logic [31:0] mbin [32];
  logic [31:0] mtot;
  logic        pend_vld;
  int          pend_bin;
  int          busy_left;
  logic        exp_valid;
  logic [31:0] exp_data;
  logic [31:0][31:0] frc;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t     rtab [7];
  logic [31:0] stab [5];

  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return (x == 32'hFFFFFFFF) ? x : x + 32'd1;
  endfunction

  function automatic int bin_of(input logic [31:0] lat);
    logic [31:0] b;
    b = lat / 8;
    return (b > 31) ? 31 : int'(b);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mbin[i] = '0;
    mtot = '0; pend_vld = 1'b0; pend_bin = 0; busy_left = 0;
    exp_valid = 1'b0; exp_data = '0;
  endtask

  task automatic model_edge(input logic r, input logic v, input logic [31:0] lat,
                            input logic clr, input logic rd, input logic [7:0] addr);
    logic busy;
    if (r) begin
      model_reset();
      return;
    end
    busy = (busy_left > 0);
    exp_valid = rd;
    if (rd) exp_data = (addr[7] || busy) ? 32'd0 : mbin[int'(addr[6:2])];
    if (busy) mtot = '0;
    else if (pend_vld) begin
      mbin[pend_bin] = sat_inc(mbin[pend_bin]);
      mtot = sat_inc(mtot);
    end
    pend_vld = v && !busy;
    pend_bin = bin_of(lat);
    if (clr) busy_left = 32;
    else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) for (int i = 0; i < 32; i++) mbin[i] = '0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [31:0] lat,
                      input logic clr, input logic rd, input logic [7:0] addr);
    rst = r; lat_valid = v; lat_cycles = lat; clear_stats = clr;
    hist_rd = rd; hist_addr = addr;
    @(posedge clk);
    model_edge(r, v, lat, clr, rd, addr);
    @(negedge clk);
    chk("hist_valid",   {31'd0, hist_valid}, {31'd0, exp_valid});
    chk("hist_data",    hist_data, exp_data);
    chk("clear_busy",   {31'd0, clear_busy}, {31'd0, busy_left > 0});
    chk("sample_total", sample_total, mtot);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic sample(input logic [31:0] lat);
    step(1'b0, 1'b1, lat, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic rd_word(input logic [7:0] addr, output logic [31:0] d);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, addr);
    d = hist_data;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 8'd0);
  endtask

  initial begin
    logic [31:0] d;
    int busy_cnt;

    stab[0] = 32'd0; stab[1] = 32'd7; stab[2] = 32'd8;
    stab[3] = 32'd255; stab[4] = 32'hFFFFFFFF;
    rtab[0] = '{8'h00, 32'd2};
    rtab[1] = '{8'h04, 32'd1};
    rtab[2] = '{8'h7C, 32'd2};
    rtab[3] = '{8'h08, 32'd0};
    rtab[4] = '{8'h07, 32'd1};
    rtab[5] = '{8'hFC, 32'd0};
    rtab[6] = '{8'h80, 32'd0};

    rst = 1'b1; lat_valid = 1'b0; lat_cycles = '0; clear_stats = 1'b0;
    hist_rd = 1'b0; hist_addr = '0;
    model_reset();
    @(negedge clk);
    do_reset();
    chk("reset_hist_valid", {31'd0, hist_valid}, 32'd0);
    chk("reset_busy", {31'd0, clear_busy}, 32'd0);

    // All words read zero after reset, each with a one-cycle valid pulse.
    for (int i = 0; i < 32; i++) begin
      rd_word(8'(i * 4), d);
      chk("rst_read_valid", {31'd0, hist_valid}, 32'd1);
      chk("rst_read_data", d, 32'd0);
    end
    idle(1);
    chk("valid_drop", {31'd0, hist_valid}, 32'd0);

    // Single samples across bin boundaries and the overflow bin.
    for (int i = 0; i < 5; i++) sample(stab[i]);
    idle(2);
    for (int i = 0; i < 7; i++) begin
      rd_word(rtab[i].addr, d);
      chk("tab_read", d, rtab[i].exp);
    end
    chk("tab_total", sample_total, 32'd5);

    // Same-bin stream: read coinciding with the last update sees 9, then 10.
    do_reset();
    for (int i = 0; i < 10; i++) sample(32'd20);
    rd_word(8'h08, d);
    chk("stream_pre_inc", d, 32'd9);
    rd_word(8'h08, d);
    chk("stream_post_inc", d, 32'd10);

    // Clear with traffic streaming through the sweep.
    for (int i = 0; i < 20; i++) sample(32'($urandom_range(0, 400)));
    busy_cnt = 0;
    step(1'b0, 1'b1, 32'd16, 1'b1, 1'b0, 8'd0);
    if (clear_busy) busy_cnt++;
    for (int i = 0; i < 31; i++) begin
      sample(32'($urandom_range(0, 400)));
      if (clear_busy) busy_cnt++;
    end
    idle(1);
    chk("sweep_len", 32'(busy_cnt), 32'd32);
    chk("sweep_done", {31'd0, clear_busy}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      rd_word(8'(i * 4), d);
      chk("post_clear_bin", d, 32'd0);
    end
    chk("post_clear_total", sample_total, 32'd0);
    sample(32'd100);
    idle(1);
    rd_word(8'h30, d);
    chk("first_post_clear", d, 32'd1);
    chk("first_post_total", sample_total, 32'd1);

    // Saturation: preload bin5 just below the limit.
    do_reset();
    frc = '0;
    frc[5] = 32'hFFFFFFFE;
    force dut.bin_q = frc;
    idle(1);
    release dut.bin_q;
    mbin[5] = 32'hFFFFFFFE;
    for (int i = 0; i < 3; i++) sample(32'd40);
    idle(2);
    rd_word(8'h14, d);
    chk("saturate", d, 32'hFFFFFFFF);

    // Reset on the 10th sweep cycle with a sample and a read in flight.
    do_reset();
    for (int i = 0; i < 8; i++) sample(32'(i * 9));
    step(1'b0, 1'b1, 32'd5, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 8; i++) sample(32'd30);
    step(1'b0, 1'b1, 32'd30, 1'b0, 1'b1, 8'h04);
    step(1'b1, 1'b1, 32'd30, 1'b0, 1'b0, 8'd0);
    chk("midrst_busy", {31'd0, clear_busy}, 32'd0);
    chk("midrst_valid", {31'd0, hist_valid}, 32'd0);
    sample(32'd50);
    idle(2);
    rd_word(8'h18, d);
    chk("post_rst_sample", d, 32'd1);
    for (int i = 0; i < 32; i++) if (i != 6) begin
      rd_word(8'(i * 4), d);
      chk("midrst_bin", d, 32'd0);
    end

    // Randomized traffic, clears and occasional resets against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] lat;
      lat = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 300));
      step(1'($urandom_range(0, 999) == 0), 1'($urandom_range(0, 1)), lat,
           1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
